// File: rtl/alu_mul_seq_pkg.sv
// Shared ALU control encodings and sequencer state type.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Imported by the multiply sequencer, the ALU port mux, the ALU and the decoder
// so that every block agrees on the OP/Function encoding of the 8-bit ALU.
package alu_mul_seq_pkg;

    // ALU OP field
    localparam logic [1:0] OP_ARITH = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_LOGIC = 2'b10;
    localparam logic [1:0] OP_SHIFT = 2'b11;

    // ALU Function field (meaning depends on OP)
    localparam logic [1:0] FN_ADD = 2'b00;  // with OP_ARITH
    localparam logic [1:0] FN_BEQ = 2'b01;  // with OP_ARITH, Zero = (A == B)
    localparam logic [1:0] FN_SLL = 2'b00;  // with OP_SHIFT
    localparam logic [1:0] FN_SRL = 2'b01;  // with OP_SHIFT

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TEST = 3'd1,
        ST_ADD  = 3'd2,
        ST_SHA  = 3'd3,
        ST_SHB  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

endpackage

// File: rtl/alu_mul_seq_alu_port_mux.sv
// ALU port owner select: core request when idle, sequencer drive when busy.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the core is expected to stall on Busy.
//
// Ports: sel_seq_i selects the sequencer side; core_*_i / seq_*_i are the two
// candidate ALU requests; alu_*_o go to ALU InputA/InputB/OP/Function.
module alu_port_mux #(
    parameter int WIDTH = 8
) (
    input  logic             sel_seq_i,
    input  logic [WIDTH-1:0] core_a_i,
    input  logic [WIDTH-1:0] core_b_i,
    input  logic [1:0]       core_op_i,
    input  logic [1:0]       core_func_i,
    input  logic [WIDTH-1:0] seq_a_i,
    input  logic [WIDTH-1:0] seq_b_i,
    input  logic [1:0]       seq_op_i,
    input  logic [1:0]       seq_func_i,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [1:0]       alu_op_o,
    output logic [1:0]       alu_func_o
);

    always_comb begin
        if (sel_seq_i) begin
            alu_a_o    = seq_a_i;
            alu_b_o    = seq_b_i;
            alu_op_o   = seq_op_i;
            alu_func_o = seq_func_i;
        end else begin
            alu_a_o    = core_a_i;
            alu_b_o    = core_b_i;
            alu_op_o   = core_op_i;
            alu_func_o = core_func_i;
        end
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier (product mod 2^WIDTH) built only from the shared ALU's add/sll/srl/beq.
// Latency: Done pulses 1 + per-iteration (TEST [+ADD] + SHA + SHB) + final TEST cycles after the Start edge.
// Backpressure: Busy high in every non-IDLE state; core stalls, Start and Core* are ignored meanwhile.
//
// Ports: Clk/Reset_n; Start/MulA/MulB request; Core* idle pass-through request;
// AluOut/AluZero from the ALU; Alu* to the ALU; Busy/Done/Product/Iters status.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] MulA,
    input  logic [WIDTH-1:0] MulB,
    input  logic [WIDTH-1:0] CoreA,
    input  logic [WIDTH-1:0] CoreB,
    input  logic [1:0]       CoreOp,
    input  logic [1:0]       CoreFunc,
    input  logic [WIDTH-1:0] AluOut,
    input  logic             AluZero,
    output logic [WIDTH-1:0] AluA,
    output logic [WIDTH-1:0] AluB,
    output logic [1:0]       AluOp,
    output logic [1:0]       AluFunc,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Product,
    output logic [3:0]       Iters
);

    // Iteration counter shares the 4-bit Iters width; WIDTH must stay below 16.
    localparam logic [3:0] CNT_MAX = 4'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, product_q;
    logic [3:0]       cnt_q, iters_q;

    logic [WIDTH-1:0] seq_a, seq_b;
    logic [1:0]       seq_op, seq_func;

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic. The early-exit test relies on the ALU's BEQ Zero flag
    // for mplier == 0 rather than a local comparator.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (Start) state_d = ST_TEST;
            ST_TEST: begin
                if ((AluZero && (EARLY_EXIT != 0)) || (cnt_q == CNT_MAX))
                    state_d = ST_DONE;
                else if (mplier_q[0])
                    state_d = ST_ADD;
                else
                    state_d = ST_SHA;
            end
            ST_ADD:  state_d = ST_SHA;
            ST_SHA:  state_d = ST_SHB;
            ST_SHB:  state_d = ST_TEST;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer ALU drive, decoded from state only. IDLE/DONE park on a
    // harmless BEQ 0,0 (IDLE drive is never selected by the mux anyway).
    always_comb begin
        seq_a    = '0;
        seq_b    = '0;
        seq_op   = OP_ARITH;
        seq_func = FN_BEQ;
        case (state_q)
            ST_TEST: begin
                seq_a = mplier_q;
            end
            ST_ADD: begin
                seq_a    = acc_q;
                seq_b    = mcand_q;
                seq_func = FN_ADD;
            end
            ST_SHA: begin
                seq_a    = mcand_q;
                seq_b    = WIDTH'(1);
                seq_op   = OP_SHIFT;
                seq_func = FN_SLL;
            end
            ST_SHB: begin
                seq_a    = mplier_q;
                seq_b    = WIDTH'(1);
                seq_op   = OP_SHIFT;
                seq_func = FN_SRL;
            end
            default: ;
        endcase
    end

    assign Busy = (state_q != ST_IDLE);
    assign Done = (state_q == ST_DONE);

    // Datapath registers; every arithmetic result comes back through AluOut.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            iters_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (Start) begin
                    mcand_q  <= MulA;
                    mplier_q <= MulB;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                end
                ST_ADD: acc_q <= AluOut;
                ST_SHA: mcand_q <= AluOut;
                ST_SHB: begin
                    mplier_q <= AluOut;
                    cnt_q    <= cnt_q + 4'd1;
                end
                default: ;
            endcase
            // Result is committed on the edge that enters DONE and then held.
            if (state_q == ST_TEST && state_d == ST_DONE) begin
                product_q <= acc_q;
                iters_q   <= cnt_q;
            end
        end
    end

    assign Product = product_q;
    assign Iters   = iters_q;

    alu_port_mux #(.WIDTH(WIDTH)) u_port_mux (
        .sel_seq_i   (Busy),
        .core_a_i    (CoreA),
        .core_b_i    (CoreB),
        .core_op_i   (CoreOp),
        .core_func_i (CoreFunc),
        .seq_a_i     (seq_a),
        .seq_b_i     (seq_b),
        .seq_op_i    (seq_op),
        .seq_func_i  (seq_func),
        .alu_a_o     (AluA),
        .alu_b_o     (AluB),
        .alu_op_o    (AluOp),
        .alu_func_o  (AluFunc)
    );

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq: two instances (EARLY_EXIT=1 and 0), each wired
// to a small behavioural 8-bit ALU, exercised with hand-computed vectors.
module tb_alu_mul_seq;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Start0 = 1'b0, Start1 = 1'b0;
    logic [7:0] MulA = '0, MulB = '0;
    logic [7:0] CoreA = '0, CoreB = '0;
    logic [1:0] CoreOp = '0, CoreFunc = '0;

    logic [7:0] alu_a0, alu_b0, alu_out0, prod0;
    logic [1:0] alu_op0, alu_fn0;
    logic       zero0, busy0, done0;
    logic [3:0] iters0;

    logic [7:0] alu_a1, alu_b1, alu_out1, prod1;
    logic [1:0] alu_op1, alu_fn1;
    logic       zero1, busy1, done1;
    logic [3:0] iters1;

    int checks = 0;
    int errors = 0;
    int cyc;

    always #5 Clk = ~Clk;

    // Behavioural ALU: ADD 00/00, BEQ 00/01 (A-B), SLL 11/00, SRL 11/01.
    function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [1:0] fn,
                                         input logic [7:0] a, input logic [7:0] b);
        if (op == 2'b11) return (fn == 2'b00) ? (a << b[2:0]) : (a >> b[2:0]);
        if (op == 2'b00) return (fn == 2'b00) ? (a + b) : (a - b);
        return a & b;
    endfunction

    assign alu_out0 = alu_f(alu_op0, alu_fn0, alu_a0, alu_b0);
    assign zero0    = (alu_out0 == 8'h00);
    assign alu_out1 = alu_f(alu_op1, alu_fn1, alu_a1, alu_b1);
    assign zero1    = (alu_out1 == 8'h00);

    alu_mul_seq #(.WIDTH(8), .EARLY_EXIT(1)) dut0 (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start0), .MulA(MulA), .MulB(MulB),
        .CoreA(CoreA), .CoreB(CoreB), .CoreOp(CoreOp), .CoreFunc(CoreFunc),
        .AluOut(alu_out0), .AluZero(zero0),
        .AluA(alu_a0), .AluB(alu_b0), .AluOp(alu_op0), .AluFunc(alu_fn0),
        .Busy(busy0), .Done(done0), .Product(prod0), .Iters(iters0)
    );

    alu_mul_seq #(.WIDTH(8), .EARLY_EXIT(0)) dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start1), .MulA(MulA), .MulB(MulB),
        .CoreA(CoreA), .CoreB(CoreB), .CoreOp(CoreOp), .CoreFunc(CoreFunc),
        .AluOut(alu_out1), .AluZero(zero1),
        .AluA(alu_a1), .AluB(alu_b1), .AluOp(alu_op1), .AluFunc(alu_fn1),
        .Busy(busy1), .Done(done1), .Product(prod1), .Iters(iters1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One multiply on instance `which`. cyc counts cycles after the accepting
    // edge (cyc=1 is the first TEST cycle), so Done at k+N gives cyc == N.
    task automatic do_mul(input bit which, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_p, input logic [3:0] exp_it,
                          input int exp_lat, input string tag);
        MulA = a;
        MulB = b;
        if (which) Start1 = 1'b1; else Start0 = 1'b1;
        tick();
        Start0 = 1'b0;
        Start1 = 1'b0;
        cyc = 1;
        while (!(which ? done1 : done0) && cyc < 200) begin
            tick();
            cyc++;
        end
        chk({tag, "_done_seen"}, 32'(which ? done1 : done0), 32'd1);
        chk({tag, "_latency"},   32'(cyc), 32'(exp_lat));
        chk({tag, "_product"},   32'(which ? prod1 : prod0), 32'(exp_p));
        chk({tag, "_iters"},     32'(which ? iters1 : iters0), 32'(exp_it));
        tick();
        chk({tag, "_idle_after"}, 32'(which ? busy1 : busy0), 32'd0);
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_busy",    32'(busy0),  32'd0);
        chk("rst_done",    32'(done0),  32'd0);
        chk("rst_product", 32'(prod0),  32'd0);
        chk("rst_iters",   32'(iters0), 32'd0);
        #9 Reset_n = 1'b1;
        tick();

        // Idle pass-through
        CoreOp = 2'b10; CoreFunc = 2'b00; CoreA = 8'h0F; CoreB = 8'hF0;
        #1;
        chk("pt_op",   32'(alu_op0), 32'h2);
        chk("pt_func", 32'(alu_fn0), 32'h0);
        chk("pt_a",    32'(alu_a0),  32'h0F);
        chk("pt_b",    32'(alu_b0),  32'hF0);
        chk("pt_busy", 32'(busy0),   32'd0);

        // Core inputs must not reach the ALU while busy: first TEST drives BEQ mplier,0
        MulA = 8'd3; MulB = 8'd5; Start0 = 1'b1;
        tick();
        Start0 = 1'b0;
        chk("busy_test_a",  32'(alu_a0),  32'h05);
        chk("busy_test_b",  32'(alu_b0),  32'h00);
        chk("busy_test_op", 32'({alu_op0, alu_fn0}), 32'h1);
        chk("busy_flag",    32'(busy0), 32'd1);
        while (busy0) tick();

        do_mul(1'b0, 8'd3,   8'd5,   8'h0F, 4'd3, 13, "m3x5");
        do_mul(1'b0, 8'd20,  8'd20,  8'h90, 4'd5, 19, "m20x20");
        do_mul(1'b0, 8'd9,   8'd0,   8'h00, 4'd0, 2,  "m9x0");
        do_mul(1'b1, 8'd7,   8'd0,   8'h00, 4'd8, 26, "ee0_7x0");
        do_mul(1'b1, 8'd3,   8'd5,   8'h0F, 4'd8, 28, "ee0_3x5");
        do_mul(1'b0, 8'd255, 8'd255, 8'h01, 4'd8, 34, "m255x255");

        // Start during Busy is ignored; Product holds the previous result meanwhile
        MulA = 8'd3; MulB = 8'd5; Start0 = 1'b1;
        tick();
        Start0 = 1'b0;
        repeat (3) tick();
        chk("hold_product", 32'(prod0), 32'h01);
        MulA = 8'd9; MulB = 8'd9; Start0 = 1'b1;
        cyc = 0;
        while (!done0 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("sdb_done_seen", 32'(done0), 32'd1);
        chk("sdb_product",   32'(prod0), 32'h0F);
        chk("sdb_iters",     32'(iters0), 32'd3);
        Start0 = 1'b0;
        begin
            int extra = 0;
            repeat (6) begin
                tick();
                if (done0 || busy0) extra++;
            end
            chk("sdb_no_second_op", 32'(extra), 32'd0);
        end

        // Async reset in ADD state
        MulA = 8'd3; MulB = 8'd5; Start0 = 1'b1;
        tick();
        Start0 = 1'b0;
        cyc = 0;
        while (!(busy0 && alu_op0 == 2'b00 && alu_fn0 == 2'b00) && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("arst_reached_add", 32'(busy0 && alu_op0 == 2'b00 && alu_fn0 == 2'b00), 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_busy",    32'(busy0), 32'd0);
        chk("arst_done",    32'(done0), 32'd0);
        chk("arst_product", 32'(prod0), 32'd0);
        #10 Reset_n = 1'b1;
        tick();
        CoreOp = 2'b01; CoreFunc = 2'b10; CoreA = 8'hA5; CoreB = 8'h5A;
        #1;
        chk("arst_pt_a",  32'(alu_a0), 32'hA5);
        chk("arst_pt_b",  32'(alu_b0), 32'h5A);
        chk("arst_pt_op", 32'({alu_op0, alu_fn0}), 32'h6);
        do_mul(1'b0, 8'd3, 8'd5, 8'h0F, 4'd3, 13, "post_rst_3x5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle sequencer that owns the shared 8-bit ALU ports (InputA, InputB, OP, Function) and consumes Out and Zero.
- Idle: core's ALU request passes straight through, combinationally.
- Busy: performs an unsigned shift-add multiply, product taken mod 2^WIDTH, using only ALU add, sll, srl and beq ops; core must stall.
- Sits between the decode/execute stage and the ALU instance.

Parameters:
WIDTH, 8, operand/result width; must match ALU datapath width
EARLY_EXIT, 1, 1 = finish when multiplier reaches zero; 0 = always run WIDTH iterations

Ports:
Clk  input  1  rising-edge clock
Reset_n  input  1  asynchronous active-low reset
Start  input  1  request multiply; sampled only in IDLE
MulA  input  WIDTH  multiplicand
MulB  input  WIDTH  multiplier
CoreA  input  WIDTH  core InputA, passed through when idle
CoreB  input  WIDTH  core InputB, passed through when idle
CoreOp  input  2  core OP, passed through when idle
CoreFunc  input  2  core Function, passed through when idle
AluOut  input  WIDTH  ALU Out
AluZero  input  1  ALU Zero
AluA  output  WIDTH  to ALU InputA
AluB  output  WIDTH  to ALU InputB
AluOp  output  2  to ALU OP
AluFunc  output  2  to ALU Function
Busy  output  1  high in every state except IDLE; core stalls while high
Done  output  1  one-cycle pulse, high only in DONE
Product  output  WIDTH  result register, held until next completion
Iters  output  4  iterations executed by last multiply

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE; mcand, mplier, acc, Product, Iters, iteration counter all cleared to 0.
  - Busy=0, Done=0.
  - Reset mid-operation aborts immediately. No Done is produced and Product reads 0.
- Encodings, fixed:
  - ADD = OP 00 / Func 00
  - BEQ = 00/01
  - SLL = 11/00
  - SRL = 11/01
- States: IDLE, TEST, ADD, SHA, SHB, DONE. Registered state; ALU drive is combinational from state.
- IDLE:
  - ALU ports = Core* pass-through.
  - Start=1 at an edge → latch mcand=MulA, mplier=MulB, acc=0, cnt=0; next state TEST.
- TEST:
  - Drive BEQ with A=mplier, B=0.
  - Next state:
    - AluZero=1 and EARLY_EXIT=1 → DONE.
    - cnt==WIDTH → DONE (regardless of EARLY_EXIT).
    - Otherwise mplier[0]=1 → ADD; else → SHA.
- ADD: drive ADD A=acc, B=mcand; acc<=AluOut (wraps mod 2^WIDTH); → SHA.
- SHA: drive SLL A=mcand, B=1; mcand<=AluOut; → SHB.
- SHB: drive SRL A=mplier, B=1; mplier<=AluOut; cnt<=cnt+1; → TEST.
- Product/Iters update and DONE exit:
  - Product<=acc and Iters<=cnt at the edge entering DONE.
  - DONE: Done=1, Busy=1, ALU drives BEQ with A=0, B=0 (harmless); → IDLE next edge.
- Start while Busy is ignored; no queueing. Start held high in DONE has no effect. Start high in the following IDLE cycle begins a new operation.
- Core* inputs are ignored while Busy; no ALU side effects leak to the core.
- Latency after the accepting edge k: Done is high in cycle k + 1 + Σ per iteration (TEST + optional ADD + SHA + SHB) + final TEST.
  - B=0: Done at k+2.
  - EARLY_EXIT=0: the loop always runs WIDTH iterations.
- No use of the ALU's SLT/ORR/SUB ops.

Decomposition:
- Shared package: ALU OP/Function encoding constants (OP_ARITH=00, OP_MEM=01, OP_LOGIC=10, OP_SHIFT=11; FN_ADD, FN_BEQ, FN_SLL, FN_SRL) and the state enum. The ALU and decoder also use these.
- One natural sub-module: alu_port_mux. It selects Core* versus sequencer drive based on Busy. Everything else stays in one FSM module.

Test Plan:
- Idle pass-through: Start=0, CoreOp=10, CoreFunc=00, CoreA=0x0F, CoreB=0xF0 → AluOp/Func/A/B mirror the Core* inputs the same cycle; Busy=0.
- 3×5, EARLY_EXIT=1: Start for one cycle → states TEST,ADD,SHA,SHB,TEST,SHA,SHB,TEST,ADD,SHA,SHB,TEST,DONE; Done high exactly at k+13; Product=0x0F; Iters=3.
- Wrap: 20×20 → Product=0x90 (400 mod 256); 255×255 → Product=0x01; Iters=8.
- Zero multiplier: MulB=0 → Done at k+2, Product=0x00, Iters=0. With EARLY_EXIT=0 and 7×0 → Iters=8, Product=0.
- Start during Busy: assert Start with new operands mid-operation → result equals the first operation's product; no second Done until a new Start is seen in IDLE.
- Async reset: drop Reset_n in ADD state between clock edges → Busy, Done, Product go 0 immediately. After release, IDLE pass-through resumes and a fresh 3×5 gives 0x0F.
